// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, R0 index and select/data typedefs
// for the scoreboarded register file.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int R0_IDX     = 0;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] sel_t;
endpackage

// File: rtl/register_file_sb_if.sv
// rtl/register_file_sb_if.sv - write-back, read and reservation bus of the register file.
// The master is the pipeline side (issue and write-back); the slave is the register file.
interface register_file_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [DATA_W-1:0] in;
  logic              wen;
  logic [ADDR_W-1:0] wsel;
  logic [ADDR_W-1:0] asel;
  logic [ADDR_W-1:0] bsel;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_sel;
  logic              a_busy;
  logic              b_busy;
  logic [ADDR_W:0]   pend_cnt;
  logic              rsv_err;
  logic              wb_err;

  modport master (
    output in, wen, wsel, asel, bsel, rsv_en, rsv_sel,
    input  a_out, b_out, a_busy, b_busy, pend_cnt, rsv_err, wb_err
  );

  modport slave (
    input  in, wen, wsel, asel, bsel, rsv_en, rsv_sel,
    output a_out, b_out, a_busy, b_busy, pend_cnt, rsv_err, wb_err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write bits, pending count and error pulses.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write into the busy lookups.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wen,
  input  logic [ADDR_W-1:0] wsel,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_sel,
  input  logic [ADDR_W-1:0] asel,
  input  logic [ADDR_W-1:0] bsel,
  output logic              a_busy,
  output logic              b_busy,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              rsv_err,
  output logic              wb_err
);
  localparam int              DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] R0_SEL = ADDR_W'(R0_IDX);
  localparam logic [ADDR_W:0]   ONE    = {{ADDR_W{1'b0}}, 1'b1};

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [ADDR_W:0]  pend_cnt_q, pend_cnt_d;
  logic             rsv_err_q, rsv_err_d;
  logic             wb_err_q, wb_err_d;
  logic             wen_eff, rsv_eff, same_reg, inc, dec;

  // With ZERO_REG, anything aimed at R0 is dropped before it reaches the scoreboard.
  assign wen_eff  = wen    && !(ZERO_REG != 0 && wsel == R0_SEL);
  assign rsv_eff  = rsv_en && !(ZERO_REG != 0 && rsv_sel == R0_SEL);
  assign same_reg = wen_eff && rsv_eff && (wsel == rsv_sel);
  assign inc      = rsv_eff && !pend_q[rsv_sel];
  assign dec      = wen_eff && pend_q[wsel] && !same_reg;

  always_comb begin
    pend_d = pend_q;
    if (wen_eff) pend_d[wsel] = 1'b0;
    if (rsv_eff) pend_d[rsv_sel] = 1'b1;

    pend_cnt_d = pend_cnt_q;
    if (inc && !dec)      pend_cnt_d = pend_cnt_q + ONE;
    else if (dec && !inc) pend_cnt_d = pend_cnt_q - ONE;

    rsv_err_d = rsv_eff && pend_q[rsv_sel];
    wb_err_d  = wen_eff && !pend_q[wsel] && !same_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      pend_cnt_q <= '0;
      rsv_err_q  <= 1'b0;
      wb_err_q   <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      rsv_err_q  <= rsv_err_d;
      wb_err_q   <= wb_err_d;
    end
  end

  always_comb begin
    a_busy = pend_q[asel];
    b_busy = pend_q[bsel];
`ifdef REGFILE_BYPASS_EN
    if (wen_eff && wsel == asel) a_busy = rsv_eff && (rsv_sel == asel);
    if (wen_eff && wsel == bsel) b_busy = rsv_eff && (rsv_sel == bsel);
`endif
    if (ZERO_REG != 0 && asel == R0_SEL) a_busy = 1'b0;
    if (ZERO_REG != 0 && bsel == R0_SEL) b_busy = 1'b0;
  end

  assign pend_cnt = pend_cnt_q;
  assign rsv_err  = rsv_err_q;
  assign wb_err   = wb_err_q;
endmodule

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - 1W/2R register file with a pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards write-back data to the read ports in the same cycle.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input logic               clk,
  input logic               reset,
  register_file_sb_if.slave bus
);
  localparam int              DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] R0_SEL = ADDR_W'(R0_IDX);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] a_rd, b_rd;
  logic              wen_eff;

  assign wen_eff = bus.wen && !(ZERO_REG != 0 && bus.wsel == R0_SEL);

  always_comb begin
    regs_d = regs_q;
    if (wen_eff) regs_d[bus.wsel] = bus.in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // R0 forcing comes last so the bypass can never leak data onto a hardwired zero.
  always_comb begin
    a_rd = regs_q[bus.asel];
    b_rd = regs_q[bus.bsel];
`ifdef REGFILE_BYPASS_EN
    if (wen_eff && bus.wsel == bus.asel) a_rd = bus.in;
    if (wen_eff && bus.wsel == bus.bsel) b_rd = bus.in;
`endif
    if (ZERO_REG != 0 && bus.asel == R0_SEL) a_rd = '0;
    if (ZERO_REG != 0 && bus.bsel == R0_SEL) b_rd = '0;
  end

  assign bus.a_out = a_rd;
  assign bus.b_out = b_rd;

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .wen      (bus.wen),
    .wsel     (bus.wsel),
    .rsv_en   (bus.rsv_en),
    .rsv_sel  (bus.rsv_sel),
    .asel     (bus.asel),
    .bsel     (bus.bsel),
    .a_busy   (bus.a_busy),
    .b_busy   (bus.b_busy),
    .pend_cnt (bus.pend_cnt),
    .rsv_err  (bus.rsv_err),
    .wb_err   (bus.wb_err)
  );
endmodule
